// File: rtl/fpu_pkg.sv
// Shared types, constants and MAC helper functions for the column scheduler
// and its 3x3 multiply-accumulate datapath.
package fpu_pkg;

    typedef logic [7:0]        pixel_t;
    typedef logic signed [7:0] coef_t;

    localparam int TAPS      = 9;
    localparam int COL_W_DEF = 10;
    localparam int ACC_W     = 20;

    typedef pixel_t [COL_W_DEF-1:0] col_t;

    // IDLE: waiting for start | FILL: first 3 columns | RUN: streaming
    // DRAIN: waiting for final result | DONE: one-cycle completion pulse
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    function automatic logic signed [ACC_W-1:0] mac_tap(input pixel_t p, input coef_t c);
        logic signed [ACC_W-1:0] w_p;
        logic signed [ACC_W-1:0] w_c;
        w_p = ACC_W'(signed'({1'b0, p}));
        w_c = ACC_W'(c);
        return w_p * w_c;
    endfunction

    function automatic pixel_t clamp_px(input logic signed [ACC_W-1:0] s);
        if (s[ACC_W-1]) begin
            return 8'h00;
        end
        if (s > ACC_W'(255)) begin
            return 8'hFF;
        end
        return s[7:0];
    endfunction

endpackage

// File: rtl/fpu_col_sched_if.sv
// Strip streaming interface: filter load, strip start, column input and
// result output handshakes plus status pulses.
interface fpu_col_sched_if #(
    parameter int COL_WIDTH = 10,
    parameter int CNT_W     = 16
);
    import fpu_pkg::*;

    logic                     filt_load;
    coef_t [TAPS-1:0]         filt_in;
    logic                     start;
    logic [CNT_W-1:0]         num_cols;
    pixel_t [COL_WIDTH-1:0]   col_in;
    logic                     col_valid;
    logic                     col_ready;
    pixel_t [COL_WIDTH-3:0]   out_pixels;
    logic                     out_valid;
    logic                     out_ready;
    logic                     out_last;
    logic                     busy;
    logic                     done;
    logic                     cfg_err;

    modport master (
        output filt_load, filt_in, start, num_cols, col_in, col_valid, out_ready,
        input  col_ready, out_pixels, out_valid, out_last, busy, done, cfg_err
    );

    modport slave (
        input  filt_load, filt_in, start, num_cols, col_in, col_valid, out_ready,
        output col_ready, out_pixels, out_valid, out_last, busy, done, cfg_err
    );

endinterface

// File: rtl/FPUMAC.sv
// Combinational 3x3 MAC over a three-column window; one clamped result per
// output row j using window rows j..j+2. Tap index = row*3 + column (w0=col 0).
module FPUMAC
    import fpu_pkg::*;
#(
    parameter int COL_WIDTH = 10
) (
    input  pixel_t [COL_WIDTH-1:0] i_w0,
    input  pixel_t [COL_WIDTH-1:0] i_w1,
    input  pixel_t [COL_WIDTH-1:0] i_w2,
    input  coef_t  [TAPS-1:0]      i_filt,
    output pixel_t [COL_WIDTH-3:0] o_res
);

    for (genvar j = 0; j < COL_WIDTH-2; j++) begin : g_out
        logic signed [ACC_W-1:0] w_sum;

        assign w_sum = mac_tap(i_w0[j],   i_filt[0]) + mac_tap(i_w1[j],   i_filt[1])
                     + mac_tap(i_w2[j],   i_filt[2]) + mac_tap(i_w0[j+1], i_filt[3])
                     + mac_tap(i_w1[j+1], i_filt[4]) + mac_tap(i_w2[j+1], i_filt[5])
                     + mac_tap(i_w0[j+2], i_filt[6]) + mac_tap(i_w1[j+2], i_filt[7])
                     + mac_tap(i_w2[j+2], i_filt[8]);

        assign o_res[j] = clamp_px(w_sum);
    end

endmodule

// File: rtl/fpu_col_sched.sv
// Column scheduler: slides a 3-column window over a strip of pixel columns and
// emits one registered, clamped 3x3 MAC result per window with valid/ready flow.
module fpu_col_sched
    import fpu_pkg::*;
#(
    parameter int COL_WIDTH = 10,
    parameter int CNT_W     = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    fpu_col_sched_if.slave    bus
);

    state_t                  r_state;
    state_t                  w_next;
    pixel_t [COL_WIDTH-1:0]  r_win0;
    pixel_t [COL_WIDTH-1:0]  r_win1;
    pixel_t [COL_WIDTH-1:0]  r_win2;
    coef_t  [TAPS-1:0]       r_filt;
    logic   [CNT_W-1:0]      r_num_cols;
    logic   [CNT_W-1:0]      r_acc;
    logic                    r_pend;
    logic                    r_out_valid;
    logic                    r_out_last;
    logic                    r_cfg_err;
    pixel_t [COL_WIDTH-3:0]  r_out_pixels;
    pixel_t [COL_WIDTH-3:0]  w_mac;

    logic w_col_ready;
    logic w_accept;
    logic w_stall;
    logic w_out_fire;
    logic w_start_ok;
    logic w_start_bad;

    assign w_stall     = r_out_valid && !bus.out_ready;
    assign w_out_fire  = r_out_valid && bus.out_ready;
    assign w_start_ok  = (r_state == IDLE) && bus.start && (bus.num_cols >= CNT_W'(3));
    assign w_start_bad = (r_state == IDLE) && bus.start && (bus.num_cols <  CNT_W'(3));
    assign w_accept    = bus.col_valid && w_col_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_col_ready = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ok) begin
                    w_next = FILL;
                end
            end
            FILL: begin
                w_col_ready = 1'b1;
                if (bus.col_valid && (r_acc == CNT_W'(2))) begin
                    w_next = RUN;
                end
            end
            RUN: begin
                w_col_ready = !r_pend && !w_stall && (r_acc < r_num_cols);
                if (r_acc == r_num_cols) begin
                    w_next = DRAIN;
                end
            end
            DRAIN: begin
                if (w_out_fire && r_out_last) begin
                    w_next = DONE;
                end
            end
            DONE:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Filter only changes in IDLE, so it is stable for the whole strip.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt <= '0;
            r_win0 <= '0;
            r_win1 <= '0;
            r_win2 <= '0;
        end else begin
            if ((r_state == IDLE) && bus.filt_load) begin
                r_filt <= bus.filt_in;
            end
            if (w_accept) begin
                r_win0 <= r_win1;
                r_win1 <= r_win2;
                r_win2 <= bus.col_in;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_num_cols   <= '0;
            r_acc        <= '0;
            r_pend       <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_last   <= 1'b0;
            r_out_pixels <= '0;
            r_cfg_err    <= 1'b0;
        end else begin
            r_cfg_err <= w_start_bad;
            if (w_start_ok) begin
                r_num_cols  <= bus.num_cols;
                r_acc       <= '0;
                r_pend      <= 1'b0;
                r_out_valid <= 1'b0;
                r_out_last  <= 1'b0;
            end else begin
                if (w_accept) begin
                    r_acc <= r_acc + CNT_W'(1);
                end
                r_pend <= w_accept && (r_acc >= CNT_W'(2));
                // pend only follows a shift, which needs the output slot free
                if (r_pend) begin
                    r_out_valid  <= 1'b1;
                    r_out_pixels <= w_mac;
                    r_out_last   <= (r_acc == r_num_cols);
                end else if (w_out_fire) begin
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                end
            end
        end
    end

    FPUMAC #(
        .COL_WIDTH (COL_WIDTH)
    ) u_mac (
        .i_w0   (r_win0),
        .i_w1   (r_win1),
        .i_w2   (r_win2),
        .i_filt (r_filt),
        .o_res  (w_mac)
    );

    assign bus.col_ready  = w_col_ready;
    assign bus.out_pixels = r_out_pixels;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_last   = r_out_last;
    assign bus.busy       = (r_state != IDLE);
    assign bus.done       = (r_state == DONE);
    assign bus.cfg_err    = r_cfg_err;

endmodule

// File: tb/tb_fpu_col_sched.sv
// Randomized bench for fpu_col_sched; results are compared with a direct
// 3x3 convolution model over the stimulus columns.
module tb_fpu_col_sched;
    import fpu_pkg::*;

    localparam int COLW = 10;
    localparam int CW   = 16;
    localparam int OUTW = (COLW-2)*8;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fpu_col_sched_if #(.COL_WIDTH(COLW), .CNT_W(CW)) bus ();

    fpu_col_sched #(.COL_WIDTH(COLW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int g_pix  [64][COLW];
    int g_filt [TAPS];

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int ref_pix(input int k, input int j);
        int s;
        s = 0;
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                s += g_pix[k+c][j+r] * g_filt[r*3+c];
            end
        end
        if (s < 0)   s = 0;
        if (s > 255) s = 255;
        return s;
    endfunction

    function automatic logic [OUTW-1:0] ref_vec(input int k);
        logic [OUTW-1:0] v;
        for (int j = 0; j < COLW-2; j++) begin
            v[j*8 +: 8] = 8'(ref_pix(k, j));
        end
        return v;
    endfunction

    function automatic col_t col_vec(input int k);
        col_t v;
        for (int i = 0; i < COLW; i++) begin
            v[i] = pixel_t'(g_pix[k][i]);
        end
        return v;
    endfunction

    task automatic idle_inputs();
        bus.filt_load = 1'b0;
        bus.filt_in   = '0;
        bus.start     = 1'b0;
        bus.num_cols  = '0;
        bus.col_in    = '0;
        bus.col_valid = 1'b0;
        bus.out_ready = 1'b0;
    endtask

    task automatic load_filter();
        @(negedge clk);
        bus.filt_load = 1'b1;
        for (int i = 0; i < TAPS; i++) bus.filt_in[i] = coef_t'(g_filt[i]);
        @(negedge clk);
        bus.filt_load = 1'b0;
    endtask

    task automatic set_filter_all(input int v);
        for (int i = 0; i < TAPS; i++) g_filt[i] = v;
    endtask

    task automatic rand_filter(input int mag);
        for (int i = 0; i < TAPS; i++) g_filt[i] = int'($urandom_range(0, 2*mag)) - mag;
    endtask

    task automatic rand_pixels(input int n);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < COLW; i++) g_pix[k][i] = int'($urandom_range(0, 255));
    endtask

    task automatic const_pixels(input int n, input int base, input int step);
        for (int k = 0; k < n; k++)
            for (int i = 0; i < COLW; i++) g_pix[k][i] = base + step*k;
    endtask

    // Runs one strip of n columns; stall holds out_ready low for that many
    // cycles on the first result, mid_load pulses filt_load while busy.
    task automatic run_strip(input int n, input int stall, input bit rnd, input bit mid_load);
        int ci;
        int ri;
        int stall_left;
        bit stalling;
        logic [OUTW-1:0] held;
        ci = 0;
        ri = 0;
        stall_left = stall;
        held = '0;
        @(negedge clk);
        bus.start    = 1'b1;
        bus.num_cols = CW'(n);
        @(negedge clk);
        bus.start = 1'b0;
        for (int cyc = 0; cyc < 400 && ri < n-2; cyc++) begin
            bus.filt_load = mid_load && (cyc == 6);
            for (int i = 0; i < TAPS; i++) bus.filt_in[i] = coef_t'($urandom_range(0, 255));
            bus.col_valid = (ci < n) && (!rnd || ($urandom_range(0, 2) != 0));
            bus.col_in    = (ci < n) ? col_vec(ci) : '0;
            stalling      = bus.out_valid && (stall_left > 0);
            bus.out_ready = stalling ? 1'b0 : (!rnd || ($urandom_range(0, 3) != 0));
            #1;
            if (stalling) begin
                if (stall_left == stall) held = bus.out_pixels;
                else chk("hold_pixels", bus.out_pixels, held);
                chk("hold_col_ready", bus.col_ready, 1'b0);
                stall_left--;
            end
            if (bus.col_valid && bus.col_ready) ci++;
            if (bus.out_valid && bus.out_ready) begin
                chk($sformatf("result_%0d", ri), bus.out_pixels, ref_vec(ri));
                chk($sformatf("last_%0d", ri), bus.out_last, (ri == n-3));
                ri++;
            end
            @(negedge clk);
        end
        bus.filt_load = 1'b0;
        bus.col_valid = 1'b0;
        bus.out_ready = 1'b0;
        #1;
        chk("result_count", ri, n-2);
        chk("done_pulse", bus.done, 1'b1);
        chk("busy_at_done", bus.busy, 1'b1);
        @(negedge clk);
        #1;
        chk("done_cleared", bus.done, 1'b0);
        chk("busy_cleared", bus.busy, 1'b0);
    endtask

    initial begin
        int acc;
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_col_ready", bus.col_ready, 1'b0);
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_out_last", bus.out_last, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_cfg_err", bus.cfg_err, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // identity filter on value-filled columns
        set_filter_all(0);
        g_filt[4] = 1;
        const_pixels(5, 10, 10);
        load_filter();
        run_strip(5, 0, 1'b0, 1'b0);

        // rejected starts
        for (int t = 0; t < 3; t++) begin
            @(negedge clk);
            bus.start     = 1'b1;
            bus.num_cols  = CW'(t);
            bus.col_valid = 1'b1;
            @(negedge clk);
            bus.start = 1'b0;
            #1;
            chk("cfg_err_pulse", bus.cfg_err, 1'b1);
            chk("cfg_err_busy", bus.busy, 1'b0);
            chk("cfg_err_col_ready", bus.col_ready, 1'b0);
            @(negedge clk);
            #1;
            chk("cfg_err_clear", bus.cfg_err, 1'b0);
            chk("cfg_err_busy2", bus.busy, 1'b0);
            bus.col_valid = 1'b0;
        end

        // back-pressure on the first result
        rand_filter(3);
        rand_pixels(6);
        load_filter();
        run_strip(6, 5, 1'b0, 1'b0);

        // clamp low and high
        set_filter_all(-1);
        const_pixels(4, 255, 0);
        load_filter();
        run_strip(4, 0, 1'b0, 1'b0);
        set_filter_all(1);
        const_pixels(4, 100, 0);
        load_filter();
        run_strip(4, 0, 1'b0, 1'b0);

        // reset after the 4th column of an 8-column strip
        rand_filter(2);
        rand_pixels(8);
        load_filter();
        @(negedge clk);
        bus.start    = 1'b1;
        bus.num_cols = CW'(8);
        @(negedge clk);
        bus.start = 1'b0;
        acc = 0;
        for (int cyc = 0; cyc < 100 && acc < 4; cyc++) begin
            bus.col_valid = 1'b1;
            bus.col_in    = col_vec(acc);
            bus.out_ready = 1'b1;
            #1;
            if (bus.col_ready) acc++;
            if (acc < 4) @(negedge clk);
        end
        chk("reset_reached_col4", acc, 4);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_busy", bus.busy, 1'b0);
        chk("midrst_col_ready", bus.col_ready, 1'b0);
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_out_last", bus.out_last, 1'b0);
        chk("midrst_done", bus.done, 1'b0);
        @(negedge clk);
        idle_inputs();
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("postrst_out_valid", bus.out_valid, 1'b0);
        chk("postrst_done", bus.done, 1'b0);
        chk("postrst_busy", bus.busy, 1'b0);
        rand_filter(3);
        rand_pixels(8);
        load_filter();
        run_strip(8, 0, 1'b1, 1'b0);

        // filt_load while busy must not disturb the strip
        rand_filter(4);
        rand_pixels(7);
        load_filter();
        run_strip(7, 0, 1'b1, 1'b1);

        // random strips with random flow control
        for (int s = 0; s < 6; s++) begin
            int n;
            n = int'($urandom_range(3, 12));
            rand_filter(3);
            rand_pixels(n);
            load_filter();
            run_strip(n, (s == 2) ? 3 : 0, 1'b1, 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
